// File: rtl/ddr_ring_pkg.sv
// Shared types and helpers for the DDR ring-buffer address generator.
package ddr_ring_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    // Advance a ring pointer by one burst, folding back to base at the region end.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] base,
                                             input logic [31:0] len, input logic [31:0] burst);
        logic [32:0] nxt;
        logic [32:0] lim;
        nxt = {1'b0, ptr} + {1'b0, burst};
        lim = {1'b0, base} + {1'b0, len};
        return (nxt == lim) ? base : nxt[31:0];
    endfunction

endpackage

// File: rtl/ddr_ring_addr_gen_if.sv
// Command channel from the address generator to the DDR controller front end.
interface ddr_ring_addr_gen_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int CH_W       = 1
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [CH_W-1:0]       cmd_ch;

    modport master (output cmd_valid, output cmd_write, output cmd_addr, output cmd_ch,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_write, input  cmd_addr, input  cmd_ch,
                    output cmd_ready);
endinterface

// File: rtl/ddr_rr_arbiter.sv
// N-requester round-robin arbiter; priority moves past the winner on advance.
module ddr_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] prio_reg;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant_idx = '0;
        grant     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(prio_reg) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) grant_idx = IDX_W'(idx);
        end
        if (|req) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_reg <= '0;
        end else if (advance) begin
            prio_reg <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/ddr_ring_addr_gen.sv
// Ring-buffer DDR address generator: per-channel write/read pointers and fill
// levels, round-robin burst arbitration and a single registered command slot.
module ddr_ring_addr_gen
    import ddr_ring_pkg::*;
#(
    parameter int ADDR_WIDTH = 25,
    parameter int NCH        = 2,
    parameter int BURST      = 8,
    parameter int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_load,
    input  logic [NCH*ADDR_WIDTH-1:0] cfg_base,
    input  logic [NCH*ADDR_WIDTH-1:0] cfg_len,
    input  logic [NCH-1:0]            wr_req,
    input  logic [NCH-1:0]            rd_req,
    ddr_ring_addr_gen_if.master       cmd,
    output logic [NCH-1:0]            rd_allow,
    output logic [NCH-1:0]            wr_allow,
    output logic [NCH*(ADDR_WIDTH+1)-1:0] fill
);
    localparam int FW     = ADDR_WIDTH + 1;
    localparam int NREQ   = 2 * NCH;
    localparam int RIDX_W = $clog2(NREQ);
    localparam logic [FW-1:0] B1 = FW'(BURST);
    localparam logic [FW-1:0] B2 = FW'(2 * BURST);

    state_e                state_reg;
    logic [ADDR_WIDTH-1:0] base_reg  [NCH];
    logic [ADDR_WIDTH-1:0] len_reg   [NCH];
    logic [ADDR_WIDTH-1:0] wptr_reg  [NCH];
    logic [ADDR_WIDTH-1:0] rptr_reg  [NCH];
    logic [FW-1:0]         fill_reg  [NCH];
    logic [ADDR_WIDTH-1:0] wptr_next [NCH];
    logic [ADDR_WIDTH-1:0] rptr_next [NCH];
    logic [FW-1:0]         fill_next [NCH];

    logic                  cmd_valid_reg;
    logic                  cmd_write_reg;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg;
    logic [CH_W-1:0]       cmd_ch_reg;

    logic                  accept;
    logic                  load_cmd;
    logic [NREQ-1:0]       req_vec;
    logic [NREQ-1:0]       grant;
    logic [RIDX_W-1:0]     grant_idx;
    logic [CH_W-1:0]       gnt_ch;
    logic                  gnt_dir;

    // A pending command on a channel is charged against its eligibility so the
    // slot can be reloaded in the same cycle it is accepted without over-issue.
    always_comb begin
        accept   = cmd_valid_reg & cmd.cmd_ready;
        req_vec  = '0;
        rd_allow = '0;
        wr_allow = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            logic          pend_here;
            logic [FW-1:0] space;
            pend_here     = cmd_valid_reg && (cmd_ch_reg == CH_W'(ch));
            space         = {1'b0, len_reg[ch]} - fill_reg[ch];
            wptr_next[ch] = wptr_reg[ch];
            rptr_next[ch] = rptr_reg[ch];
            fill_next[ch] = fill_reg[ch];
            if (accept && pend_here) begin
                if (cmd_write_reg == ~DIR_WR) begin
                    wptr_next[ch] = ADDR_WIDTH'(wrap_inc(32'(wptr_reg[ch]), 32'(base_reg[ch]),
                                                         32'(len_reg[ch]), 32'(BURST)));
                    fill_next[ch] = fill_reg[ch] + B1;
                end else begin
                    rptr_next[ch] = ADDR_WIDTH'(wrap_inc(32'(rptr_reg[ch]), 32'(base_reg[ch]),
                                                         32'(len_reg[ch]), 32'(BURST)));
                    fill_next[ch] = fill_reg[ch] - B1;
                end
            end
            wr_allow[ch] = space >= B1;
            rd_allow[ch] = fill_reg[ch] >= B1;
            req_vec[2*ch + int'(DIR_WR)] = wr_req[ch] &&
                (space >= ((pend_here && cmd_write_reg) ? B2 : B1));
            req_vec[2*ch + int'(DIR_RD)] = rd_req[ch] &&
                (fill_reg[ch] >= ((pend_here && !cmd_write_reg) ? B2 : B1));
        end
        gnt_ch   = CH_W'(grant_idx >> 1);
        gnt_dir  = grant_idx[0];
        load_cmd = (state_reg == RUN) && !cfg_load && (|grant) && (!cmd_valid_reg || accept);
    end

    ddr_rr_arbiter #(
        .N     (NREQ),
        .IDX_W (RIDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_vec),
        .advance   (load_cmd),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cmd_valid_reg <= 1'b0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_ch_reg    <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                base_reg[ch] <= '0;
                len_reg[ch]  <= '0;
                wptr_reg[ch] <= '0;
                rptr_reg[ch] <= '0;
                fill_reg[ch] <= '0;
            end
        end else if (cfg_load) begin
            // A handshake in this cycle is consumed but its pointer effects are dropped.
            state_reg     <= RUN;
            cmd_valid_reg <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                base_reg[ch] <= cfg_base[ch*ADDR_WIDTH +: ADDR_WIDTH];
                len_reg[ch]  <= cfg_len[ch*ADDR_WIDTH +: ADDR_WIDTH];
                wptr_reg[ch] <= cfg_base[ch*ADDR_WIDTH +: ADDR_WIDTH];
                rptr_reg[ch] <= cfg_base[ch*ADDR_WIDTH +: ADDR_WIDTH];
                fill_reg[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                wptr_reg[ch] <= wptr_next[ch];
                rptr_reg[ch] <= rptr_next[ch];
                fill_reg[ch] <= fill_next[ch];
            end
            if (load_cmd) begin
                cmd_valid_reg <= 1'b1;
                cmd_write_reg <= (gnt_dir == DIR_WR);
                cmd_addr_reg  <= (gnt_dir == DIR_WR) ? wptr_next[gnt_ch] : rptr_next[gnt_ch];
                cmd_ch_reg    <= gnt_ch;
            end else if (accept) begin
                cmd_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                assert (fill_reg[ch] <= {1'b0, len_reg[ch]});
            end
        end
    end

    assign cmd.cmd_valid = cmd_valid_reg;
    assign cmd.cmd_write = cmd_write_reg;
    assign cmd.cmd_addr  = cmd_addr_reg;
    assign cmd.cmd_ch    = cmd_ch_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_fill
            assign fill[gi*FW +: FW] = fill_reg[gi];
        end
    endgenerate
endmodule
